// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter over 0..MODULUS-1 with load, wrap/saturate,
// terminal count, Gray-coded output and a sticky out-of-range load flag.
module updown_counter_mod #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             sat_en,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_gray,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

   generate
      if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
         $error("updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
      end
   endgenerate

   logic             at_max;
   logic             at_zero;
   logic             load_oor;
   logic [WIDTH-1:0] count_next;
   logic             wrap_next;
   logic             err_next;

   assign at_max   = (count == MAX_COUNT);
   assign at_zero  = (count == '0);
   assign load_oor = ({1'b0, load_value} >= MOD_EXT);
   assign tc       = enable & ((mode & at_max) | (~mode & at_zero));

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      count_next = count;
      wrap_next  = 1'b0;
      err_next   = load_err;
      if (load) begin
         if (load_oor) begin
            count_next = MAX_COUNT;
            err_next   = 1'b1;
         end else begin
            count_next = load_value;
         end
      end else if (enable) begin
         if (mode) begin
            if (!at_max) begin
               count_next = count + ONE;
            end else if (!sat_en) begin
               count_next = '0;
               wrap_next  = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               count_next = count - ONE;
            end else if (!sat_en) begin
               count_next = MAX_COUNT;
               wrap_next  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         count_gray <= '0;
         wrap       <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values regardless of statement order.
         count      <= count_next;
         count_gray <= count_next ^ (count_next >> 1);
         wrap       <= wrap_next;
         load_err   <= err_next;
      end
   end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod (WIDTH=4, MODULUS=10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       mode;
   logic       load;
   logic [3:0] load_value;
   logic       sat_en;
   logic [3:0] count;
   logic [3:0] count_gray;
   logic       tc;
   logic       wrap;
   logic       load_err;

   int checks   = 0;
   int failures = 0;

   updown_counter_mod #(.WIDTH(4), .MODULUS(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_value (load_value),
      .sat_en     (sat_en),
      .count      (count),
      .count_gray (count_gray),
      .tc         (tc),
      .wrap       (wrap),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One rising edge, then back to the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_state(input string tag, input logic [3:0] c, input logic [3:0] g,
                               input logic t, input logic w, input logic e);
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".gray"},  32'(count_gray), 32'(g));
      check({tag, ".tc"},    32'(tc), 32'(t));
      check({tag, ".wrap"},  32'(wrap), 32'(w));
      check({tag, ".err"},   32'(load_err), 32'(e));
   endtask

   // Hand-computed Gray codes of 0..9.
   logic [3:0] gray_tab [10] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13};

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 1'b1; load = 1'b0;
      load_value = 4'd0; sat_en = 1'b0;

      #30;
      expect_state("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Up-count through a full wrap.
      reset = 1'b0; enable = 1'b1; mode = 1'b1; sat_en = 1'b0;
      check("up0.tc", 32'(tc), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         step();
         expect_state($sformatf("up%0d", i), 4'(i % 10), gray_tab[i % 10],
                      (i % 10) == 9, i == 10, 1'b0);
      end

      // Down-count wrap from a loaded 2.
      load = 1'b1; load_value = 4'd2; mode = 1'b0;
      step(); expect_state("dn_load", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
      load = 1'b0;
      step(); expect_state("dn1", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      step(); expect_state("dn0", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step(); expect_state("dn9", 4'd9, 4'd13, 1'b0, 1'b1, 1'b0);
      step(); expect_state("dn8", 4'd8, 4'd12, 1'b0, 1'b0, 1'b0);

      // Saturation at the top, then reverse.
      load = 1'b1; load_value = 4'd7; mode = 1'b1; sat_en = 1'b1;
      step(); expect_state("sat_load", 4'd7, 4'd4, 1'b0, 1'b0, 1'b0);
      load = 1'b0;
      step(); expect_state("sat8", 4'd8, 4'd12, 1'b0, 1'b0, 1'b0);
      step(); expect_state("sat9", 4'd9, 4'd13, 1'b1, 1'b0, 1'b0);
      step(); expect_state("sat9b", 4'd9, 4'd13, 1'b1, 1'b0, 1'b0);
      step(); expect_state("sat9c", 4'd9, 4'd13, 1'b1, 1'b0, 1'b0);
      mode = 1'b0;
      #1 check("sat_rev.tc", 32'(tc), 32'd0);
      step(); expect_state("sat_rev", 4'd8, 4'd12, 1'b0, 1'b0, 1'b0);

      // Saturation at the bottom.
      load = 1'b1; load_value = 4'd0;
      step(); load = 1'b0;
      step(); expect_state("satlo", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

      // Out-of-range load and sticky error.
      load = 1'b1; load_value = 4'd12; sat_en = 1'b0; mode = 1'b1;
      step(); expect_state("oor", 4'd9, 4'd13, 1'b1, 1'b0, 1'b1);
      load = 1'b0;
      step(); expect_state("oor_wrap", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      step(); expect_state("oor_cnt", 4'd1, 4'd1, 1'b0, 1'b0, 1'b1);

      // Load beats enable, then hold.
      load = 1'b1; enable = 1'b1; load_value = 4'd4;
      step(); expect_state("prio", 4'd4, 4'd6, 1'b0, 1'b0, 1'b1);
      load = 1'b0; enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); expect_state($sformatf("hold%0d", i), 4'd4, 4'd6, 1'b0, 1'b0, 1'b1);
      end

      // Asynchronous reset between edges at count 6.
      enable = 1'b1;
      step(); step();
      expect_state("pre_rst", 4'd6, 4'd5, 1'b0, 1'b0, 1'b1);
      #2 reset = 1'b1;
      #1 expect_state("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Reset also kills a wrap pulse in flight.
      reset = 1'b0; load = 1'b1; load_value = 4'd9;
      step(); expect_state("ld9", 4'd9, 4'd13, 1'b1, 1'b0, 1'b0);
      load = 1'b0;
      step(); check("wrap_fly", 32'(wrap), 32'd1);
      #1 reset = 1'b1;
      #1 check("wrap_kill", 32'(wrap), 32'd0);
      reset = 1'b0;

      // MODULUS itself is out of range.
      load = 1'b1; load_value = 4'd10;
      step(); expect_state("ld10", 4'd9, 4'd13, 1'b1, 1'b0, 1'b1);
      load = 1'b0; enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
